// File: rtl/s_axil_regfile.sv
// rtl/s_axil_regfile.sv - AXI4-Lite slave register file: NUM_RW control registers plus NUM_RO status words
module s_axil_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_RW = 6,
  parameter int NUM_RO = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int ST_W = ((NUM_RO > 0) ? NUM_RO : 1) * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [ADDR_WIDTH-1:0]        awaddr_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [STRB_W-1:0]            wstrb_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  input  logic [ADDR_WIDTH-1:0]        araddr_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [NUM_RW*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_RW-1:0]            wr_pulse_o,
  input  logic [ST_W-1:0]              status_i
);

  typedef enum logic {W_COLLECT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam logic [ADDR_WIDTH-1:0] RW_END = ADDR_WIDTH'(NUM_RW);
  localparam logic [ADDR_WIDTH-1:0] RO_END = ADDR_WIDTH'(NUM_RW + NUM_RO);
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;

  logic                  r_awready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [DATA_WIDTH-1:0] r_regs [NUM_RW];
  logic [NUM_RW-1:0]     r_wr_pulse;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_hs, w_w_hs, w_commit, w_b_hs, w_ar_hs, w_r_hs;
  logic [ADDR_WIDTH-1:0] w_aw_idx, w_ar_idx;
  logic [1:0]            w_wr_resp, w_rd_resp;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_aw_hs  = awvalid_i && r_awready;
  assign w_w_hs   = wvalid_i && r_wready;
  // Both ready flags low while collecting means address and data are latched.
  assign w_commit = (r_wstate == W_COLLECT) && !r_awready && !r_wready;
  assign w_b_hs   = r_bvalid && bready_i;
  assign w_ar_hs  = arvalid_i && (r_rstate == R_IDLE);
  assign w_r_hs   = (r_rstate == R_DATA) && rready_i;

  assign w_aw_idx = r_awaddr >> ADDR_LSB;
  assign w_ar_idx = araddr_i >> ADDR_LSB;

  always_comb begin
    w_wr_resp = RESP_DECERR;
    if (w_aw_idx < RW_END)
      w_wr_resp = RESP_OKAY;
    else if (w_aw_idx < RO_END)
      w_wr_resp = RESP_SLVERR;
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_DECERR;
    for (int i = 0; i < NUM_RW; i++) begin
      if (w_ar_idx == ADDR_WIDTH'(i)) begin
        w_rd_data = r_regs[i];
        w_rd_resp = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (w_ar_idx == ADDR_WIDTH'(NUM_RW + j)) begin
        w_rd_data = status_i[j*DATA_WIDTH +: DATA_WIDTH];
        w_rd_resp = RESP_OKAY;
      end
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_COLLECT: if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP:    if (w_b_hs) w_wstate_nxt = W_COLLECT;
      default:   w_wstate_nxt = W_COLLECT;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_wstate <= W_COLLECT;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_RW; i++) r_regs[i] <= RESET_VAL;
    end else begin
      r_wr_pulse <= '0;
      if (w_aw_hs) begin
        r_awready <= 1'b0;
        r_awaddr  <= awaddr_i;
      end
      if (w_w_hs) begin
        r_wready <= 1'b0;
        r_wdata  <= wdata_i;
        r_wstrb  <= wstrb_i;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_resp;
        for (int i = 0; i < NUM_RW; i++) begin
          if (w_aw_idx == ADDR_WIDTH'(i)) begin
            r_wr_pulse[i] <= 1'b1;
            for (int k = 0; k < STRB_W; k++)
              if (r_wstrb[k]) r_regs[i][k*8 +: 8] <= r_wdata[k*8 +: 8];
          end
        end
      end
      if (w_b_hs) begin
        r_bvalid  <= 1'b0;
        r_bresp   <= RESP_OKAY;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
    end
  end

  // Read sampling uses the pre-commit register value, so a same-edge write is not visible.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_data;
      r_rresp <= w_rd_resp;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_regs
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign awready_o  = r_awready;
  assign wready_o   = r_wready;
  assign bvalid_o   = r_bvalid;
  assign bresp_o    = r_bresp;
  assign arready_o  = (r_rstate == R_IDLE);
  assign rvalid_o   = (r_rstate == R_DATA);
  assign rdata_o    = r_rdata;
  assign rresp_o    = r_rresp;
  assign wr_pulse_o = r_wr_pulse;

endmodule

// File: tb/tb_s_axil_regfile.sv
// tb/tb_s_axil_regfile.sv - randomized self-checking bench for s_axil_regfile against a register-array model
module tb_s_axil_regfile;
  localparam int NRW = 6;
  localparam int NRO = 2;

  logic        clk = 0;
  logic        areset = 0;
  logic [31:0] awaddr_i = 0, wdata_i = 0, araddr_i = 0;
  logic [3:0]  wstrb_i = 0;
  logic        awvalid_i = 0, wvalid_i = 0, bready_i = 0, arvalid_i = 0, rready_i = 0;
  logic        awready_o, wready_o, bvalid_o, arready_o, rvalid_o;
  logic [1:0]  bresp_o, rresp_o;
  logic [31:0] rdata_o;
  logic [NRW*32-1:0] regs_o;
  logic [NRW-1:0]    wr_pulse_o;
  logic [NRO*32-1:0] status_i = 0;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model [NRW];

  s_axil_regfile dut (
    .clk(clk), .areset(areset),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .status_i(status_i)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (s[k]) m = m | (32'hFF << (8 * k));
    return (old & ~m) | (d & m);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, output logic [1:0] resp,
                          output logic [5:0] pulse, output int lat, output bit ok);
    bit aw_done, w_done;
    int cyc;
    aw_done = 0; w_done = 0; ok = 1; cyc = 0;
    awaddr_i = addr; wdata_i = data; wstrb_i = strb; bready_i = 1;
    while (!(aw_done && w_done) && ok) begin
      awvalid_i = !aw_done && (cyc >= aw_dly);
      wvalid_i  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      if (awvalid_i && awready_o) aw_done = 1;
      if (wvalid_i && wready_o) w_done = 1;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 50) ok = 0;
    end
    awvalid_i = 0; wvalid_i = 0;
    lat = 0;
    @(negedge clk);
    while (!bvalid_o && lat < 50) begin @(negedge clk); lat++; end
    if (!bvalid_o) ok = 0;
    resp = bresp_o; pulse = wr_pulse_o;
    @(posedge clk); #1;
    bready_i = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdly, output logic [31:0] data,
                         output logic [31:0] data2, output logic [1:0] resp, output int lat, output bit ok);
    int cyc;
    ok = 1; cyc = 0;
    araddr_i = addr; arvalid_i = 1; rready_i = 0;
    @(negedge clk);
    while (!arready_o && cyc < 50) begin @(negedge clk); cyc++; end
    if (!arready_o) ok = 0;
    @(posedge clk); #1;
    arvalid_i = 0;
    lat = 0;
    @(negedge clk);
    while (!rvalid_o && lat < 50) begin @(negedge clk); lat++; end
    if (!rvalid_o) ok = 0;
    data = rdata_o; resp = rresp_o;
    repeat (rdly) @(negedge clk);
    data2 = rdata_o;
    @(posedge clk); #1;
    rready_i = 1;
    @(posedge clk); #1;
    rready_i = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if ({awready_o, wready_o, arready_o} !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b want 111", {awready_o, wready_o, arready_o}); end
    n_checks++; if ({bvalid_o, rvalid_o, bresp_o, rresp_o} !== 6'b0) begin n_fail++; $display("FAIL reset_valid_resp: got %b want 0", {bvalid_o, rvalid_o, bresp_o, rresp_o}); end
    n_checks++; if (rdata_o !== 32'h0 || wr_pulse_o !== 6'h0) begin n_fail++; $display("FAIL reset_rdata_pulse: got %h/%b want 0/0", rdata_o, wr_pulse_o); end
    n_checks++; if (regs_o !== '0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", regs_o); end
    areset = 1;
    for (int i = 0; i < NRW; i++) model[i] = 32'h0;
  endtask

  task automatic test_same_cycle_write();
    @(posedge clk); #1;
    awaddr_i = 32'h04; wdata_i = 32'hDEADBEEF; wstrb_i = 4'hF; awvalid_i = 1; wvalid_i = 1; bready_i = 0;
    @(negedge clk);
    n_checks++; if (!(awready_o && wready_o)) begin n_fail++; $display("FAIL sc_ready: got %b%b want 11", awready_o, wready_o); end
    @(posedge clk); #1;
    awvalid_i = 0; wvalid_i = 0;
    @(negedge clk);
    n_checks++; if ({bvalid_o, awready_o, wready_o} !== 3'b000) begin n_fail++; $display("FAIL sc_collect: got %b want 000", {bvalid_o, awready_o, wready_o}); end
    @(negedge clk);
    model[1] = 32'hDEADBEEF;
    n_checks++; if (regs_o[32 +: 32] !== model[1]) begin n_fail++; $display("FAIL sc_reg1: got %h want %h", regs_o[32 +: 32], model[1]); end
    n_checks++; if (wr_pulse_o !== 6'b000010) begin n_fail++; $display("FAIL sc_pulse: got %b want 000010", wr_pulse_o); end
    n_checks++; if (bvalid_o !== 1'b1 || bresp_o !== 2'd0) begin n_fail++; $display("FAIL sc_b: got %b/%0d want 1/0", bvalid_o, bresp_o); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if ({bvalid_o, bresp_o, awready_o, wready_o, wr_pulse_o} !== {1'b1, 2'd0, 2'b00, 6'b0}) begin
        n_fail++; $display("FAIL sc_hold%0d: got bv=%b br=%0d aw=%b w=%b p=%b", c, bvalid_o, bresp_o, awready_o, wready_o, wr_pulse_o);
      end
    end
    @(posedge clk); #1; bready_i = 1;
    @(posedge clk); #1; bready_i = 0;
    @(negedge clk);
    n_checks++; if ({bvalid_o, awready_o, wready_o} !== 3'b011) begin n_fail++; $display("FAIL sc_release: got %b want 011", {bvalid_o, awready_o, wready_o}); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d, d2; logic [1:0] rr; int lat; bit ok;
    @(posedge clk); #1;
    wdata_i = 32'h11223344; wstrb_i = 4'b0101; wvalid_i = 1;
    @(posedge clk); #1; wvalid_i = 0;
    @(negedge clk);
    n_checks++; if ({wready_o, awready_o, bvalid_o} !== 3'b010) begin n_fail++; $display("FAIL wa_wheld: got %b want 010", {wready_o, awready_o, bvalid_o}); end
    @(posedge clk); #1; awaddr_i = 32'h08; awvalid_i = 1;
    @(posedge clk); #1; awvalid_i = 0;
    @(negedge clk);
    n_checks++; if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL wa_early_b: got %b want 0", bvalid_o); end
    @(negedge clk);
    model[2] = merge(model[2], 32'h11223344, 4'b0101);
    n_checks++; if (bvalid_o !== 1'b1 || bresp_o !== 2'd0 || regs_o[64 +: 32] !== model[2]) begin
      n_fail++; $display("FAIL wa_commit: got bv=%b br=%0d r2=%h want 1/0/%h", bvalid_o, bresp_o, regs_o[64 +: 32], model[2]);
    end
    @(posedge clk); #1; bready_i = 1;
    @(posedge clk); #1; bready_i = 0;
    do_read(32'h08, 0, d, d2, rr, lat, ok);
    n_checks++; if (!ok || d !== 32'h00220044 || rr !== 2'd0 || lat !== 0) begin
      n_fail++; $display("FAIL wa_read: got ok=%b d=%h r=%0d lat=%0d want 1/00220044/0/0", ok, d, rr, lat);
    end
  endtask

  task automatic test_ro_unmapped();
    logic [1:0] br, rr; logic [5:0] p; logic [31:0] d, d2; int lat; bit ok;
    status_i = {32'hCAFE0001, 32'h00000005};
    do_write(32'h18, 32'h12345678, 4'hF, 0, 0, br, p, lat, ok);
    n_checks++; if (!ok || br !== 2'd2 || p !== 6'b0) begin n_fail++; $display("FAIL ro_write: got ok=%b br=%0d p=%b want 1/2/0", ok, br, p); end
    for (int i = 0; i < NRW; i++) begin
      n_checks++; if (regs_o[i*32 +: 32] !== model[i]) begin n_fail++; $display("FAIL ro_regs%0d: got %h want %h", i, regs_o[i*32 +: 32], model[i]); end
    end
    do_read(32'h18, 0, d, d2, rr, lat, ok);
    n_checks++; if (!ok || d !== 32'h5 || rr !== 2'd0) begin n_fail++; $display("FAIL ro_read: got %h/%0d want 5/0", d, rr); end
    do_read(32'h1C, 0, d, d2, rr, lat, ok);
    n_checks++; if (!ok || d !== 32'hCAFE0001 || rr !== 2'd0) begin n_fail++; $display("FAIL ro_read1: got %h/%0d want cafe0001/0", d, rr); end
    do_read(32'h20, 0, d, d2, rr, lat, ok);
    n_checks++; if (!ok || d !== 32'h0 || rr !== 2'd3) begin n_fail++; $display("FAIL unmap_read: got %h/%0d want 0/3", d, rr); end
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 1, 0, br, p, lat, ok);
    n_checks++; if (!ok || br !== 2'd3 || p !== 6'b0) begin n_fail++; $display("FAIL unmap_write: got ok=%b br=%0d p=%b want 1/3/0", ok, br, p); end
  endtask

  task automatic test_collision();
    logic [1:0] br, rr; logic [5:0] p; logic [31:0] d, d2; int lat; bit ok;
    do_write(32'h0C, 32'hAAAA, 4'hF, 0, 0, br, p, lat, ok);
    model[3] = 32'hAAAA;
    @(posedge clk); #1;
    awaddr_i = 32'h0C; wdata_i = 32'h5555; wstrb_i = 4'hF; awvalid_i = 1; wvalid_i = 1; bready_i = 0;
    @(posedge clk); #1;
    awvalid_i = 0; wvalid_i = 0; araddr_i = 32'h0C; arvalid_i = 1; rready_i = 0;
    @(posedge clk); #1; arvalid_i = 0;
    @(negedge clk);
    n_checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hAAAA) begin n_fail++; $display("FAIL coll_read: got rv=%b d=%h want 1/aaaa", rvalid_o, rdata_o); end
    n_checks++; if (bvalid_o !== 1'b1 || regs_o[96 +: 32] !== 32'h5555) begin n_fail++; $display("FAIL coll_write: got bv=%b r3=%h want 1/5555", bvalid_o, regs_o[96 +: 32]); end
    model[3] = 32'h5555;
    @(posedge clk); #1; bready_i = 1; rready_i = 1;
    @(posedge clk); #1; bready_i = 0; rready_i = 0;
    do_read(32'h0C, 0, d, d2, rr, lat, ok);
    n_checks++; if (!ok || d !== 32'h5555 || rr !== 2'd0) begin n_fail++; $display("FAIL coll_reread: got %h/%0d want 5555/0", d, rr); end
  endtask

  task automatic test_stall_and_reset();
    logic [31:0] pre, nd; logic [1:0] bseen; bit saw_b; int cyc;
    pre = model[0]; nd = $urandom(); saw_b = 0; bseen = 2'bxx;
    @(posedge clk); #1;
    araddr_i = 32'h00; arvalid_i = 1; rready_i = 0;
    awaddr_i = 32'h00; wdata_i = nd; wstrb_i = 4'hF; awvalid_i = 1; wvalid_i = 1; bready_i = 1;
    @(posedge clk); #1;
    arvalid_i = 0; awvalid_i = 0; wvalid_i = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (rvalid_o !== 1'b1 || rdata_o !== pre || rresp_o !== 2'd0) begin
        n_fail++; $display("FAIL stall%0d: got rv=%b d=%h r=%0d want 1/%h/0", c, rvalid_o, rdata_o, rresp_o, pre);
      end
      if (bvalid_o && !saw_b) begin saw_b = 1; bseen = bresp_o; end
    end
    model[0] = nd;
    n_checks++; if (!saw_b || bseen !== 2'd0 || regs_o[31:0] !== nd) begin n_fail++; $display("FAIL stall_write: got saw=%b br=%0d r0=%h want 1/0/%h", saw_b, bseen, regs_o[31:0], nd); end
    @(posedge clk); #1; rready_i = 1; bready_i = 0;
    @(posedge clk); #1; rready_i = 0;
    awaddr_i = 32'h04; wdata_i = $urandom(); awvalid_i = 1; wvalid_i = 1;
    @(posedge clk); #1; awvalid_i = 0; wvalid_i = 0;
    cyc = 0;
    @(negedge clk);
    while (!bvalid_o && cyc < 20) begin @(negedge clk); cyc++; end
    n_checks++; if (bvalid_o !== 1'b1) begin n_fail++; $display("FAIL rst_setup: got bvalid %b want 1", bvalid_o); end
    #2 areset = 0;
    #1;
    n_checks++; if ({bvalid_o, rvalid_o, awready_o, wready_o, arready_o} !== 5'b00111) begin
      n_fail++; $display("FAIL rst_mid: got %b want 00111", {bvalid_o, rvalid_o, awready_o, wready_o, arready_o});
    end
    for (int i = 0; i < NRW; i++) model[i] = 32'h0;
    n_checks++; if (regs_o !== '0 || wr_pulse_o !== 6'b0) begin n_fail++; $display("FAIL rst_regs: got %h/%b want 0/0", regs_o, wr_pulse_o); end
    repeat (2) @(negedge clk);
    areset = 1;
  endtask

  task automatic test_random();
    logic [1:0] br, rr, eresp; logic [5:0] p, epulse; logic [31:0] d, d2, ed, wd; logic [3:0] ws;
    int idx, lat; bit ok; logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      status_i = {$urandom(), $urandom()};
      idx = $urandom_range(0, 9);
      addr = 32'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom(); ws = 4'($urandom_range(0, 15));
        do_write(addr, wd, ws, $urandom_range(0, 2), $urandom_range(0, 2), br, p, lat, ok);
        if (idx < NRW) begin model[idx] = merge(model[idx], wd, ws); eresp = 2'd0; epulse = 6'(1 << idx); end
        else begin eresp = (idx < NRW + NRO) ? 2'd2 : 2'd3; epulse = 6'b0; end
        n_checks++; if (!ok || br !== eresp || p !== epulse || lat !== 1) begin
          n_fail++; $display("FAIL rnd_write%0d: a=%h got ok=%b br=%0d p=%b lat=%0d want 1/%0d/%b/1", n, addr, ok, br, p, lat, eresp, epulse);
        end
      end else begin
        if (idx < NRW) begin ed = model[idx]; eresp = 2'd0; end
        else if (idx < NRW + NRO) begin ed = status_i[(idx - NRW)*32 +: 32]; eresp = 2'd0; end
        else begin ed = 32'h0; eresp = 2'd3; end
        do_read(addr, $urandom_range(0, 3), d, d2, rr, lat, ok);
        n_checks++; if (!ok || d !== ed || d2 !== ed || rr !== eresp || lat !== 0) begin
          n_fail++; $display("FAIL rnd_read%0d: a=%h got ok=%b d=%h d2=%h r=%0d lat=%0d want %h/%0d/0", n, addr, ok, d, d2, rr, lat, ed, eresp);
        end
      end
    end
    for (int i = 0; i < NRW; i++) begin
      n_checks++; if (regs_o[i*32 +: 32] !== model[i]) begin n_fail++; $display("FAIL rnd_final%0d: got %h want %h", i, regs_o[i*32 +: 32], model[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_ro_unmapped();
    test_collision();
    test_stall_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/s_axil_regfile.md
Name: s_axil_regfile

Overview:
- Parametrised AXI4-Lite slave register file: the next generation of the counter-control register block.
- Provides NUM_RW read/write control registers, driven out in parallel to the datapath, plus NUM_RO read-only status words sampled from the datapath.
- Adds over the previous block: generic data width and byte strobes, a read-only region, full OKAY/SLVERR/DECERR responses on both channels, rresp, per-register write-strobe pulses, and explicit read/write collision rules.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64 only; STRB_W = DATA_WIDTH/8
ADDR_WIDTH, 32, AXI address width
NUM_RW, 6, number of read/write registers (>=1)
NUM_RO, 2, number of read-only status words (>=0)
RESET_VAL, 0, reset value of every RW register (DATA_WIDTH bits)

Ports:
clk  in  1  clock
areset  in  1  reset
awaddr_i  in  ADDR_WIDTH  write address
awvalid_i / awready_o  in/out  1  AW handshake
wdata_i  in  DATA_WIDTH  write data
wstrb_i  in  STRB_W  byte strobes
wvalid_i / wready_o  in/out  1  W handshake
bresp_o  out  2  write response
bvalid_o / bready_i  out/in  1  B handshake
araddr_i  in  ADDR_WIDTH  read address
arvalid_i / arready_o  in/out  1  AR handshake
rdata_o  out  DATA_WIDTH  read data
rresp_o  out  2  read response
rvalid_o / rready_i  out/in  1  R handshake
regs_o  out  NUM_RW*DATA_WIDTH  RW register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse_o  out  NUM_RW  one-cycle pulse per RW register on committed write
status_i  in  max(NUM_RO,1)*DATA_WIDTH  RO words, same packing

Behaviour:
- Reset: areset is asynchronous, active-low; clock is clk.
- Values held in reset: awready_o=1, wready_o=1, arready_o=1, bvalid_o=0, rvalid_o=0, bresp_o=0, rresp_o=0, rdata_o=0, wr_pulse_o=0, all regs=RESET_VAL.
- Reset mid-transaction: all in-flight transactions are dropped and both FSMs return to idle.
- Decode:
  - idx = addr >> log2(STRB_W); low byte-offset bits are ignored.
  - idx < NUM_RW: RW region.
  - NUM_RW <= idx < NUM_RW+NUM_RO: RO region.
  - Otherwise: unmapped.
- Write FSM states: W_COLLECT, W_RESP.
  - W_COLLECT: AW and W are accepted independently, in either order or in the same cycle.
  - awready_o drops the cycle after the AW handshake; wready_o drops the cycle after the W handshake. Address, data and strobes are latched.
  - When both are held, the commit happens at the next edge:
    - RW: update byte lane k iff wstrb[k]; pulse wr_pulse_o[idx] for 1 cycle; bresp=OKAY (0).
    - RO: no update, no pulse; bresp=SLVERR (2).
    - Unmapped: no update, no pulse; bresp=DECERR (3).
  - At the commit edge, bvalid_o=1 and the FSM enters W_RESP.
  - Latency: AW+W handshake at edge N gives register update, pulse and bvalid at edge N+1.
  - W_RESP: bvalid_o and bresp_o are held stable until bready_i. On the B handshake: bvalid_o=0, bresp_o=0, awready_o=wready_o=1 next cycle, return to W_COLLECT.
  - wstrb=0 to an RW register: OKAY response and pulse asserted, data unchanged.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready_o=1.
  - On the AR handshake at edge N, rdata_o/rresp_o are loaded and rvalid_o=1 after edge N (1-cycle latency); arready_o=0.
  - RW region: register value sampled at edge N; OKAY.
  - RO region: status_i word sampled at edge N; OKAY.
  - Unmapped: rdata 0; DECERR.
  - R_DATA: rdata_o/rresp_o are held stable while rvalid_o && !rready_i. On the R handshake, rvalid_o=0 and arready_o=1 next cycle.
- Channel independence: the read and write paths operate concurrently. An outstanding B does not stall reads, and vice versa.
- Collision: if a write commit and an AR handshake to the same RW register fall on the same edge, the read returns the pre-write value.
- Ordering: at most one outstanding write and one outstanding read; no reordering.

Test Plan:
- Defaults (DW=32, 6 RW, 2 RO): AW 0x04 and W 0xDEADBEEF strb 0xF in the same cycle -> next cycle regs[1]=0xDEADBEEF, wr_pulse_o=6'b000010 for 1 cycle, bvalid=1 bresp=0; hold bready=0 for 3 cycles -> bvalid/bresp stable, awready=wready=0.
- W (0x11223344, strb 0b0101) 2 cycles before AW 0x08, on reg=0 -> regs[2]=0x00220044, bresp=0; then read 0x08 -> rdata=0x00220044, rresp=0, rvalid 1 cycle after AR handshake.
- Write 0x18 (RO) -> bresp=2, regs unchanged, no pulse; read 0x18 with status_i word0=0x5 -> rdata=0x5, rresp=0; read 0x20 -> rdata=0, rresp=3; write 0x40 -> bresp=3.
- regs[3]=0xAAAA, then a commit of 0x5555 to 0x0C on the same edge as an AR handshake on 0x0C -> rdata=0xAAAA; a subsequent read returns 0x5555.
- Read with rready held low 4 cycles while a write to 0x00 completes -> rdata stable, write completes with bresp=0; assert areset mid-W_RESP -> bvalid=0, awready=wready=arready=1, all regs=RESET_VAL.
